// File: rtl/trng_bit_collector.sv
`default_nettype none
// ============================================================================
// Module      : trng_bit_collector
// Description : Samples the oscillator edge counter once per window, reduces
//               each sample to one raw bit by parity, debiases raw bits with
//               a von Neumann corrector, packs corrected bits LSB-first into
//               words and offers them on a valid/ready interface. A
//               repetition-count health test blocks output permanently once
//               a stuck entropy source is detected.
// Ports       : clk_i      - clock, all state on rising edge
//               rst_i      - asynchronous active-high reset
//               cnt_val_i  - counter value [BW-1:0]
//               en_i       - collection enable
//               data_o     - output word [WORD_W-1:0], first bit in bit 0
//               valid_o    - data_o holds an unconsumed word
//               ready_i    - consumer accepts the word
//               fail_o     - health test failed (sticky until reset)
// Revision    : 1.0 - initial release
// ============================================================================
module trng_bit_collector #(
    parameter int BW        = 3,
    parameter int WIN_LEN   = 16,
    parameter int WORD_W    = 8,
    parameter int REP_LIMIT = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [BW-1:0]     cnt_val_i,
    input  logic              en_i,
    output logic [WORD_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              fail_o
);

    localparam int c_WC_W = $clog2(WIN_LEN);
    localparam int c_BC_W = $clog2(WORD_W);
    localparam int c_RC_W = $clog2(REP_LIMIT + 1);

    localparam logic [0:0] c_EMPTY      = 1'b0;
    localparam logic [0:0] c_HAVE_FIRST = 1'b1;

    logic [c_WC_W-1:0] r_wc;
    logic              r_raw;
    logic              r_raw_vld;
    logic              r_prev;
    logic [c_RC_W-1:0] r_rc;
    logic              r_fail;
    logic [0:0]        r_state;
    logic              r_first;
    logic [WORD_W-1:0] r_asm;
    logic [c_BC_W-1:0] r_bc;
    logic [WORD_W-1:0] r_data;
    logic              r_valid;

    logic              w_win_end;
    logic              w_step;
    logic [c_RC_W-1:0] w_rc_next;
    logic              w_trip;
    logic [0:0]        w_state_next;
    logic              w_emit;
    logic              w_bit;
    logic              w_free;
    logic              w_last;
    logic [WORD_W-1:0] w_shift;

    assign w_win_end = en_i && (r_wc == c_WC_W'(WIN_LEN - 1));

    // A raw bit is only consumed while collection is enabled and the source
    // has not been declared stuck; a sample pending when en_i drops is lost.
    assign w_step    = r_raw_vld && en_i && !r_fail;
    assign w_rc_next = ((r_rc == '0) || (r_raw != r_prev)) ? c_RC_W'(1)
                                                           : r_rc + c_RC_W'(1);
    assign w_trip    = w_step && (w_rc_next == c_RC_W'(REP_LIMIT));

    assign w_free  = !r_valid || ready_i;
    assign w_last  = (r_bc == c_BC_W'(WORD_W - 1));
    assign w_shift = {w_bit, r_asm[WORD_W-1:1]};

    // Von Neumann pairing: (0,1) -> 0, (1,0) -> 1, i.e. the emitted bit is
    // the first bit of an unequal pair. The tripping sample is not debiased
    // so the abandoned word cannot be refreshed on the failing edge.
    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        w_bit        = r_first;
        if (!en_i) begin
            w_state_next = c_EMPTY;
        end else if (w_step && !w_trip) begin
            case (r_state)
                c_EMPTY: begin
                    w_state_next = c_HAVE_FIRST;
                end
                default: begin
                    w_state_next = c_EMPTY;
                    w_emit       = (r_first != r_raw);
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wc      <= '0;
            r_raw     <= 1'b0;
            r_raw_vld <= 1'b0;
            r_prev    <= 1'b0;
            r_rc      <= '0;
            r_fail    <= 1'b0;
            r_first   <= 1'b0;
            r_asm     <= '0;
            r_bc      <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
        end else begin
            // Sampling window
            if (!en_i || w_win_end) begin
                r_wc <= '0;
            end else begin
                r_wc <= r_wc + c_WC_W'(1);
            end
            r_raw_vld <= w_win_end;
            if (w_win_end) begin
                r_raw <= ^cnt_val_i;
            end

            // Repetition-count health test
            if (w_step) begin
                r_rc   <= w_rc_next;
                r_prev <= r_raw;
                if (w_trip) begin
                    r_fail <= 1'b1;
                end
            end

            if (w_step && !w_trip && (r_state == c_EMPTY)) begin
                r_first <= r_raw;
            end

            // Handshake and word assembly. A completing bit that finds the
            // holding register busy is dropped; bc stays at WORD_W-1 so the
            // next emitted bit retries the completion.
            if (w_trip) begin
                r_valid <= 1'b0;
            end else begin
                if (r_valid && ready_i) begin
                    r_valid <= 1'b0;
                end
                if (w_emit) begin
                    if (!w_last) begin
                        r_asm <= w_shift;
                        r_bc  <= r_bc + c_BC_W'(1);
                    end else if (w_free) begin
                        r_asm   <= w_shift;
                        r_data  <= w_shift;
                        r_valid <= 1'b1;
                        r_bc    <= '0;
                    end
                end
            end
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign fail_o  = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_trng_bit_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_trng_bit_collector
// Description : Directed self-checking bench for trng_bit_collector with
//               BW=3, WIN_LEN=4, WORD_W=8, REP_LIMIT=4. Raw bit 1 is driven
//               as cnt_val 3'b001, raw bit 0 as 3'b011, one per window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trng_bit_collector;

    logic       clk;
    logic       rst;
    logic [2:0] cnt_val;
    logic       en;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       fail;

    int total = 0;
    int bad   = 0;
    int valid_cnt = 0;

    trng_bit_collector #(
        .BW(3), .WIN_LEN(4), .WORD_W(8), .REP_LIMIT(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .cnt_val_i(cnt_val), .en_i(en),
        .data_o(data), .valid_o(valid), .ready_i(ready), .fail_o(fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts cycles during which a word is offered.
    always @(negedge clk) if (valid === 1'b1) valid_cnt = valid_cnt + 1;

    // One raw bit per window; returns 1 ns after the sampling edge.
    task automatic send_bit(input logic b);
        cnt_val = b ? 3'b001 : 3'b011;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic a, input logic b);
        send_bit(a);
        send_bit(b);
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        rst = 1'b1; en = 1'b0; ready = 1'b1; cnt_val = 3'b000;
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset;
        #12;
        total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h expected 00", data); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", valid); end
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL reset_fail: got %b expected 0", fail); end
    endtask

    task automatic test_all_ones;
        do_reset();
        valid_cnt = 0;
        repeat (8) send_pair(1'b1, 1'b0);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL ones_latency: got valid %b expected 0", valid); end
        @(posedge clk); #1;
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL ones_valid: got %b expected 1", valid); end
        total++; if (data !== 8'hFF) begin bad++; $display("FAIL ones_data: got %h expected ff", data); end
        @(posedge clk); #1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL ones_valid_fall: got %b expected 0", valid); end
        total++; if (valid_cnt !== 1) begin bad++; $display("FAIL ones_pulse_len: got %0d expected 1", valid_cnt); end
    endtask

    task automatic test_mixed;
        do_reset();
        repeat (4) begin send_pair(1'b0, 1'b1); send_pair(1'b1, 1'b0); end
        @(posedge clk); #1;
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL mixed_valid: got %b expected 1", valid); end
        total++; if (data !== 8'hAA) begin bad++; $display("FAIL mixed_data: got %h expected aa", data); end
    endtask

    task automatic test_discard;
        do_reset();
        valid_cnt = 0;
        repeat (4) begin send_pair(1'b1, 1'b1); send_pair(1'b0, 1'b0); end
        total++; if (valid_cnt !== 0) begin bad++; $display("FAIL discard_novalid: got %0d cycles expected 0", valid_cnt); end
        repeat (8) send_pair(1'b1, 1'b0);
        @(posedge clk); #1;
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL discard_valid: got %b expected 1", valid); end
        total++; if (data !== 8'hFF) begin bad++; $display("FAIL discard_data: got %h expected ff", data); end
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL discard_fail: got %b expected 0", fail); end
    endtask

    task automatic test_health;
        do_reset();
        ready = 1'b0;
        repeat (8) send_pair(1'b1, 1'b0);
        repeat (4) send_bit(1'b1);
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL health_pre_fail: got %b expected 0", fail); end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL health_pre_valid: got %b expected 1", valid); end
        @(posedge clk); #1;
        total++; if (fail !== 1'b1) begin bad++; $display("FAIL health_fail: got %b expected 1", fail); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL health_valid_drop: got %b expected 0", valid); end
        ready = 1'b1;
        valid_cnt = 0;
        for (int i = 0; i < 50; i++) send_bit(i[0]);
        total++; if (valid_cnt !== 0) begin bad++; $display("FAIL health_blocked: got %0d cycles expected 0", valid_cnt); end
        total++; if (fail !== 1'b1) begin bad++; $display("FAIL health_sticky: got %b expected 1", fail); end
    endtask

    task automatic test_backpressure;
        do_reset();
        ready = 1'b0;
        repeat (12) send_pair(1'b1, 1'b0);
        total++; if (valid !== 1'b1 || data !== 8'hFF) begin bad++; $display("FAIL bp_hold: got valid %b data %h expected 1 ff", valid, data); end
        repeat (4) send_pair(1'b1, 1'b0);
        @(posedge clk); #1;
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b expected 1", valid); end
        total++; if (data !== 8'hFF) begin bad++; $display("FAIL bp_data: got %h expected ff", data); end
        en = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL bp_transfer: got valid %b expected 0", valid); end
        en = 1'b1;
        send_pair(1'b0, 1'b1);
        @(posedge clk); #1;
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL bp_retry_valid: got %b expected 1", valid); end
        total++; if (data !== 8'h7F) begin bad++; $display("FAIL bp_retry_data: got %h expected 7f", data); end
        ready = 1'b1;
    endtask

    task automatic test_reset_mid;
        do_reset();
        ready = 1'b0;
        repeat (4) begin send_pair(1'b0, 1'b1); send_pair(1'b1, 1'b0); end
        @(posedge clk); #1;
        total++; if (valid !== 1'b1 || data !== 8'hAA) begin bad++; $display("FAIL rst_pre_word: got valid %b data %h expected 1 aa", valid, data); end
        en = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        send_pair(1'b0, 1'b1); send_pair(1'b1, 1'b0); send_pair(1'b0, 1'b1);
        send_pair(1'b1, 1'b0); send_pair(1'b0, 1'b1);
        send_bit(1'b1);
        #1 rst = 1'b1;
        #1;
        total++; if (data !== 8'h00) begin bad++; $display("FAIL rst_async_data: got %h expected 00", data); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid: got %b expected 0", valid); end
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL rst_async_fail: got %b expected 0", fail); end
        #2 rst = 1'b0;
        ready = 1'b1;
        repeat (4) begin send_pair(1'b0, 1'b1); send_pair(1'b1, 1'b0); end
        @(posedge clk); #1;
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL rst_after_valid: got %b expected 1", valid); end
        total++; if (data !== 8'hAA) begin bad++; $display("FAIL rst_after_data: got %h expected aa", data); end
    endtask

    task automatic test_enable;
        do_reset();
        repeat (8) send_pair(1'b1, 1'b0);
        @(posedge clk); #1;
        total++; if (data !== 8'hFF) begin bad++; $display("FAIL en_pre_data: got %h expected ff", data); end
        en = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        send_bit(1'b1);
        en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++; if (data !== 8'hFF) begin bad++; $display("FAIL en_hold_data: got %h expected ff", data); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL en_hold_valid: got %b expected 0", valid); end
        en = 1'b1;
        repeat (8) send_pair(1'b0, 1'b1);
        @(posedge clk); #1;
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL en_after_valid: got %b expected 1", valid); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL en_after_data: got %h expected 00", data); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ready = 1'b1; cnt_val = 3'b000;
        test_reset();
        test_all_ones();
        test_mixed();
        test_discard();
        test_health();
        test_backpressure();
        test_reset_mid();
        test_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
